// File: rtl/hv_cmd_fetch_if.sv
// hv_cmd_fetch_if: queue fetch bus, CDB hand-off and status writeback bundle.
// master = the fetch block, slave = queue / command processor side.
interface hv_cmd_fetch_if #(
    parameter int unsigned CMD_IO_WIDTH = 64,
    parameter int unsigned CDB_SIZE     = 256
);
    logic                    cq_cout_ready;
    logic                    cmd_request;
    logic                    cmd_oe;
    logic [CMD_IO_WIDTH-1:0] cmd_out;
    logic                    cdb_valid;
    logic                    cdb_ready;
    logic [CDB_SIZE-1:0]     cdb_data;
    logic [7:0]              cdb_index;
    logic [7:0]              cdb_tag;
    logic                    cdb_error;
    logic                    op_done;
    logic [7:0]              op_done_index;
    logic [7:0]              op_done_status;
    logic [7:0]              op_index;
    logic [7:0]              cmd_op_status;

    modport master (
        input  cq_cout_ready, cmd_oe, cmd_out, cdb_ready,
               op_done, op_done_index, op_done_status,
        output cmd_request, cdb_valid, cdb_data, cdb_index, cdb_tag,
               cdb_error, op_index, cmd_op_status
    );

    modport slave (
        output cq_cout_ready, cmd_oe, cmd_out, cdb_ready,
               op_done, op_done_index, op_done_status,
        input  cmd_request, cdb_valid, cdb_data, cdb_index, cdb_tag,
               cdb_error, op_index, cmd_op_status
    );
endinterface

// File: rtl/hv_cmd_fetch.sv
// hv_cmd_fetch: requests one queued CDB at a time, assembles its beats,
// presents it to the command processor and forwards completion status
// back to the queue.
// Optional macro HV_FETCH_ERR_DROP_EN: drop checksum-error CDBs instead of
// presenting them, count them and write status 8 back for their slot.
module hv_cmd_fetch #(
    parameter int unsigned CMD_IO_WIDTH  = 64,
    parameter int unsigned CDB_SIZE      = 256,
    parameter int unsigned FETCH_TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset,
    hv_cmd_fetch_if.master bus,
    output logic           fetch_timeout_err,
    output logic [7:0]     err_drop_cnt,
    output logic           busy
);
    localparam int unsigned BEATS  = CDB_SIZE / CMD_IO_WIDTH;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned TO_W   = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [7:0]  ST_CKSUM_ERR = 8'd2;

    typedef enum logic [1:0] {IDLE, REQ, COLLECT, PRESENT} state_t;

    state_t            state;
    state_t            state_nx;
    logic [BEAT_W-1:0] beat_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              last_beat_c;
    logic              timeout_c;
    logic              drop_c;
    logic              op_wr_c;

    // Qualifiers for the COLLECT exits and the writeback request
    always_comb begin
        last_beat_c = (state == COLLECT) && bus.cmd_oe &&
                      (beat_cnt == BEAT_W'(BEATS - 1));
        timeout_c   = (state == COLLECT) && !bus.cmd_oe &&
                      (to_cnt == TO_W'(FETCH_TIMEOUT - 1));
        op_wr_c     = bus.op_done && (bus.op_done_status != 8'd0);
`ifdef HV_FETCH_ERR_DROP_EN
        drop_c      = last_beat_c && bus.cdb_error;
`else
        drop_c      = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.cq_cout_ready) state_nx = REQ;
            REQ:     state_nx = COLLECT;
            COLLECT: begin
                if (timeout_c)        state_nx = IDLE;
                else if (last_beat_c) state_nx = drop_c ? IDLE : PRESENT;
            end
            PRESENT: if (bus.cdb_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Registered FSM outputs, beat assembly, header capture and timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.cmd_request   <= 1'b0;
            bus.cdb_valid     <= 1'b0;
            bus.cdb_data      <= '0;
            bus.cdb_index     <= 8'd0;
            bus.cdb_tag       <= 8'd0;
            bus.cdb_error     <= 1'b0;
            busy              <= 1'b0;
            fetch_timeout_err <= 1'b0;
            beat_cnt          <= '0;
            to_cnt            <= '0;
        end else begin
            bus.cmd_request <= (state_nx == REQ);
            bus.cdb_valid   <= (state_nx == PRESENT);
            busy            <= (state_nx != IDLE);
            case (state)
                REQ: begin
                    beat_cnt      <= '0;
                    to_cnt        <= '0;
                    bus.cdb_data  <= '0;
                    bus.cdb_index <= 8'd0;
                    bus.cdb_tag   <= 8'd0;
                    bus.cdb_error <= 1'b0;
                end
                COLLECT: begin
                    if (bus.cmd_oe) begin
                        for (int b = 0; b < int'(BEATS); b++) begin
                            if (beat_cnt == BEAT_W'(b))
                                bus.cdb_data[b*CMD_IO_WIDTH +: CMD_IO_WIDTH] <= bus.cmd_out;
                        end
                        // Header lives in the first (least significant) beat
                        if (beat_cnt == '0) begin
                            bus.cdb_error <= (bus.cmd_out[31:24] == ST_CKSUM_ERR);
                            bus.cdb_index <= bus.cmd_out[23:16];
                            bus.cdb_tag   <= bus.cmd_out[15:8];
                        end
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                        to_cnt   <= '0;
                    end else if (timeout_c) begin
                        fetch_timeout_err <= 1'b1;
                        bus.cdb_data      <= '0;
                        bus.cdb_index     <= 8'd0;
                        bus.cdb_tag       <= 8'd0;
                        bus.cdb_error     <= 1'b0;
                        to_cnt            <= '0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HV_FETCH_ERR_DROP_EN
    logic       drop_pend;
    logic [7:0] drop_slot;

    // Saturating count of dropped error CDBs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                             err_drop_cnt <= 8'd0;
        else if (drop_c && err_drop_cnt != 8'hFF) err_drop_cnt <= err_drop_cnt + 8'd1;
    end

    // Status writeback; processor completions win, a displaced drop write waits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.op_index      <= 8'd0;
            bus.cmd_op_status <= 8'd0;
            drop_pend         <= 1'b0;
            drop_slot         <= 8'd0;
        end else if (op_wr_c) begin
            bus.op_index      <= bus.op_done_index;
            bus.cmd_op_status <= bus.op_done_status;
            if (drop_c) begin
                drop_pend <= 1'b1;
                drop_slot <= bus.cdb_index;
            end
        end else if (drop_pend) begin
            bus.op_index      <= drop_slot;
            bus.cmd_op_status <= 8'd8;
            if (drop_c) drop_slot <= bus.cdb_index;
            else        drop_pend <= 1'b0;
        end else if (drop_c) begin
            bus.op_index      <= bus.cdb_index;
            bus.cmd_op_status <= 8'd8;
        end else begin
            bus.cmd_op_status <= 8'd0;
        end
    end
`else
    assign err_drop_cnt = 8'd0;

    // Status writeback: one-cycle status pulse, index holds afterwards
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.op_index      <= 8'd0;
            bus.cmd_op_status <= 8'd0;
        end else if (op_wr_c) begin
            bus.op_index      <= bus.op_done_index;
            bus.cmd_op_status <= bus.op_done_status;
        end else begin
            bus.cmd_op_status <= 8'd0;
        end
    end
`endif
endmodule

// File: tb/tb_hv_cmd_fetch.sv
// tb_hv_cmd_fetch: directed, table-driven bench for hv_cmd_fetch.
module tb_hv_cmd_fetch;
    typedef struct {
        logic [7:0] st;
        logic [7:0] idx;
        logic [7:0] tag;
        int         gap;
        int         hold;
        logic       exp_err;
    } fvec_t;

    typedef struct {
        logic [7:0] idx;
        logic [7:0] st;
        logic [7:0] exp_st;
    } wvec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       fetch_timeout_err;
    logic [7:0] err_drop_cnt;
    logic       busy;
    int         total = 0;
    int         bad = 0;
    int         req_cnt = 0;
    int         exp_drop = 0;
    logic [7:0] exp_opi;
    fvec_t      tv[5];
    wvec_t      wv[4];

    hv_cmd_fetch_if #(.CMD_IO_WIDTH(64), .CDB_SIZE(256)) bus ();

    hv_cmd_fetch dut (
        .clk               (clk),
        .reset             (reset),
        .bus               (bus),
        .fetch_timeout_err (fetch_timeout_err),
        .err_drop_cnt      (err_drop_cnt),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.cmd_request === 1'b1) req_cnt <= req_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] mk_beat(input int i, input fvec_t v);
        if (i == 0) return {32'h1234_5678, v.st, v.idx, v.tag, 8'h01};
        return {8'(i), 48'hC0FF_EE00_0000, 8'(i + 1)};
    endfunction

    // One complete fetch; pre_req means the request cycle is already current
    task automatic run_fetch(input fvec_t v, input bit keep_cq, input bit pre_req);
        logic [255:0] exp;
        logic         stable;
        int           r0;
        for (int i = 0; i < 4; i++) exp[i*64 +: 64] = mk_beat(i, v);
        if (!pre_req) begin
            bus.cq_cout_ready = 1'b1;
            tick();
            chk("req_pulse", 256'(bus.cmd_request), 256'(1));
        end
        if (!keep_cq) bus.cq_cout_ready = 1'b0;
        tick();
        chk("req_single", 256'(bus.cmd_request), 256'(0));
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) repeat (v.gap) tick();
            bus.cmd_oe  = 1'b1;
            bus.cmd_out = mk_beat(i, v);
            tick();
            bus.cmd_oe  = 1'b0;
            bus.cmd_out = 64'hDEAD_BEEF_DEAD_BEEF;
            if (i == 2) chk("valid_early", 256'(bus.cdb_valid), 256'(0));
        end
`ifdef HV_FETCH_ERR_DROP_EN
        if (v.exp_err) begin
            exp_drop++;
            exp_opi = v.idx;
            chk("drop_valid", 256'(bus.cdb_valid), 256'(0));
            chk("drop_busy", 256'(busy), 256'(0));
            chk("drop_status", 256'(bus.cmd_op_status), 256'(8));
            chk("drop_index", 256'(bus.op_index), 256'(v.idx));
            chk("drop_cnt", 256'(err_drop_cnt), 256'(exp_drop));
            tick();
            chk("drop_status_clr", 256'(bus.cmd_op_status), 256'(0));
            return;
        end
`endif
        chk("valid_latency", 256'(bus.cdb_valid), 256'(1));
        chk("cdb_data", bus.cdb_data, exp);
        chk("cdb_index", 256'(bus.cdb_index), 256'(v.idx));
        chk("cdb_tag", 256'(bus.cdb_tag), 256'(v.tag));
        chk("cdb_error", 256'(bus.cdb_error), 256'(v.exp_err));
        r0 = req_cnt;
        stable = 1'b1;
        repeat (v.hold) begin
            tick();
            if (bus.cdb_valid !== 1'b1 || bus.cdb_data !== exp) stable = 1'b0;
        end
        if (v.hold > 0) chk("hold_stable", 256'(stable), 256'(1));
        if (keep_cq) chk("no_req_in_present", 256'(req_cnt - r0), 256'(0));
        bus.cdb_ready = 1'b1;
        tick();
        bus.cdb_ready = 1'b0;
        chk("valid_drop", 256'(bus.cdb_valid), 256'(0));
        if (keep_cq) begin
            chk("req_gap1", 256'(bus.cmd_request), 256'(0));
            tick();
            chk("req_gap2", 256'(bus.cmd_request), 256'(1));
        end else begin
            chk("idle_busy", 256'(busy), 256'(0));
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.cq_cout_ready  = 1'b0;
        bus.cmd_oe         = 1'b0;
        bus.cmd_out        = '0;
        bus.cdb_ready      = 1'b0;
        bus.op_done        = 1'b0;
        bus.op_done_index  = 8'd0;
        bus.op_done_status = 8'd0;
        exp_opi            = 8'd0;

        tv[0] = '{8'h03, 8'h01, 8'hA5, 0,  0,  1'b0};
        tv[1] = '{8'h03, 8'h05, 8'h3C, 3,  2,  1'b0};
        tv[2] = '{8'h02, 8'h07, 8'h11, 0,  1,  1'b1};
        tv[3] = '{8'h00, 8'hFF, 8'hFF, 63, 0,  1'b0};
        tv[4] = '{8'hFE, 8'h00, 8'h80, 1,  10, 1'b0};

        wv[0] = '{8'h05, 8'h06, 8'h06};
        wv[1] = '{8'h09, 8'h00, 8'h00};
        wv[2] = '{8'hFF, 8'hFF, 8'hFF};
        wv[3] = '{8'h00, 8'h01, 8'h01};

        #12;
        chk("rst_cmd_request", 256'(bus.cmd_request), 256'(0));
        chk("rst_cdb_valid", 256'(bus.cdb_valid), 256'(0));
        chk("rst_cdb_data", bus.cdb_data, 256'(0));
        chk("rst_hdr", 256'({bus.cdb_index, bus.cdb_tag, bus.cdb_error}), 256'(0));
        chk("rst_wb", 256'({bus.op_index, bus.cmd_op_status}), 256'(0));
        chk("rst_err", 256'({fetch_timeout_err, err_drop_cnt, busy}), 256'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();

        for (int k = 0; k < 4; k++) run_fetch(tv[k], 1'b0, 1'b0);
        chk("no_timeout_gap63", 256'(fetch_timeout_err), 256'(0));

        // Backpressure with the queue still advertising a CDB
        run_fetch(tv[4], 1'b1, 1'b0);
        run_fetch(tv[0], 1'b0, 1'b1);

        // Writeback vectors
        for (int k = 0; k < 4; k++) begin
            bus.op_done        = 1'b1;
            bus.op_done_index  = wv[k].idx;
            bus.op_done_status = wv[k].st;
            tick();
            bus.op_done = 1'b0;
            if (wv[k].exp_st != 8'd0) exp_opi = wv[k].idx;
            chk("wb_status", 256'(bus.cmd_op_status), 256'(wv[k].exp_st));
            chk("wb_index", 256'(bus.op_index), 256'(exp_opi));
            tick();
            chk("wb_status_clr", 256'(bus.cmd_op_status), 256'(0));
        end

        // Back-to-back completions
        bus.op_done = 1'b1; bus.op_done_index = 8'h03; bus.op_done_status = 8'h11;
        tick();
        bus.op_done_index = 8'h04; bus.op_done_status = 8'h22;
        chk("b2b_first", 256'({bus.op_index, bus.cmd_op_status}), 256'(16'h0311));
        tick();
        bus.op_done = 1'b0;
        chk("b2b_second", 256'({bus.op_index, bus.cmd_op_status}), 256'(16'h0422));
        tick();
        chk("b2b_clr", 256'(bus.cmd_op_status), 256'(0));

`ifdef HV_FETCH_ERR_DROP_EN
        // Drop write collides with a completion and is deferred one cycle
        bus.cq_cout_ready = 1'b1;
        tick();
        bus.cq_cout_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.cmd_oe  = 1'b1;
            bus.cmd_out = mk_beat(i, tv[2]);
            if (i == 3) begin
                bus.op_done = 1'b1; bus.op_done_index = 8'h42; bus.op_done_status = 8'h33;
            end
            tick();
        end
        bus.cmd_oe = 1'b0;
        bus.op_done = 1'b0;
        exp_drop++;
        chk("coll_opdone", 256'({bus.op_index, bus.cmd_op_status}), 256'(16'h4233));
        chk("coll_valid", 256'(bus.cdb_valid), 256'(0));
        tick();
        chk("coll_drop", 256'({bus.op_index, bus.cmd_op_status}), 256'({tv[2].idx, 8'h08}));
        tick();
        chk("coll_clr", 256'(bus.cmd_op_status), 256'(0));
`endif

        // Fetch timeout: no beats at all after the request
        begin
            int n;
            logic seen_valid;
            bus.cq_cout_ready = 1'b1;
            tick();
            bus.cq_cout_ready = 1'b0;
            n = 0;
            seen_valid = 1'b0;
            while (fetch_timeout_err !== 1'b1 && n < 100) begin
                tick();
                n++;
                if (bus.cdb_valid === 1'b1) seen_valid = 1'b1;
            end
            chk("timeout_cycles", 256'(n), 256'(65));
            chk("timeout_no_valid", 256'(seen_valid), 256'(0));
            chk("timeout_busy", 256'(busy), 256'(0));
            tick();
            tick();
            chk("timeout_sticky", 256'(fetch_timeout_err), 256'(1));
        end
        chk("drop_cnt_total", 256'(err_drop_cnt), 256'(exp_drop));

        // Reset in the middle of collecting
        bus.cq_cout_ready = 1'b1;
        tick();
        bus.cq_cout_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            bus.cmd_oe  = 1'b1;
            bus.cmd_out = mk_beat(i, tv[1]);
            tick();
        end
        bus.cmd_oe = 1'b0;
        chk("mid_busy", 256'(busy), 256'(1));
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_data", bus.cdb_data, 256'(0));
        chk("mid_rst_flags", 256'({busy, bus.cdb_valid, bus.cmd_request, fetch_timeout_err}), 256'(0));
        chk("mid_rst_wb", 256'({bus.op_index, bus.cmd_op_status}), 256'(0));
        exp_drop = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        run_fetch(tv[0], 1'b0, 1'b0);
        chk("post_rst_wb", 256'(bus.cmd_op_status), 256'(0));
        chk("post_rst_drop", 256'(err_drop_cnt), 256'(exp_drop));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
